// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port memory arbiter between IF fetch and MEM load/store
//
// Purpose: shares one combinational-read byte memory port between instruction
// fetch and data accesses. Data has priority. Misaligned data accesses are
// rejected without touching memory. Every result is registered, so each
// requester sees a one-cycle valid/done pulse one cycle after its grant.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_pc/if_flush         fetch request, fetch address, discard granted fetch
//   if_valid/if_instr             registered fetch response
//   d_read/d_write/d_func3/
//   d_addr/d_wdata                data request
//   d_done/d_rdata/d_misaligned   registered data response
//   m_using/m_read/m_write/
//   m_func3/m_addr/m_wdata        memory port controls
//   m_rdata                       memory combinational read data
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_misaligned,
  output logic              m_using,
  output logic              m_read,
  output logic              m_write,
  output logic [2:0]        m_func3,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    F_RSP = 2'd1,
    D_RSP = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] if_instr_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              d_mis_q;

  logic d_req;
  logic misaligned;
  logic d_bad;
  logic d_grant;
  logic f_grant;

  assign d_req      = d_read | d_write;
  assign misaligned = ((d_func3[1:0] == 2'd2) && (d_addr[1:0] != 2'b00)) ||
                      ((d_func3[1:0] == 2'd1) && d_addr[0]);

  // Excluding the requester's own response cycle acts as the handshake ack:
  // the requester only updates its request after seeing done/valid, so a
  // request still asserted in that cycle is stale and must not be reissued.
  assign d_bad   = d_req & misaligned & (state_q != D_RSP);
  assign d_grant = d_req & ~misaligned & (state_q != D_RSP);
  assign f_grant = if_req & ~d_grant & ~d_bad & (state_q != F_RSP);

  always_comb begin
    state_d = IDLE;
    m_using = 1'b0;
    m_read  = 1'b0;
    m_write = 1'b0;
    m_func3 = 3'b000;
    m_addr  = '0;
    m_wdata = '0;
    if (d_grant) begin
      m_using = 1'b1;
      m_read  = d_read;
      // Gated by rst so a store in its grant cycle cannot land mid-reset.
      m_write = d_write & ~rst;
      m_func3 = d_func3;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      state_d = D_RSP;
    end else if (d_bad) begin
      state_d = D_RSP;
    end else if (f_grant) begin
      m_using = 1'b1;
      m_func3 = 3'b010;
      m_addr  = if_pc & WORD_MASK;
      state_d = if_flush ? IDLE : F_RSP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      if_instr_q <= '0;
      d_rdata_q  <= '0;
      d_mis_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (d_grant) begin
        d_mis_q <= 1'b0;
        if (d_read) begin
          d_rdata_q <= m_rdata;
        end
      end else if (d_bad) begin
        d_mis_q   <= 1'b1;
        d_rdata_q <= '0;
      end
      if (f_grant && !if_flush) begin
        if_instr_q <= m_rdata;
      end
    end
  end

  assign if_valid     = (state_q == F_RSP);
  assign d_done       = (state_q == D_RSP);
  assign d_misaligned = d_mis_q & (state_q == D_RSP);
  assign if_instr     = if_instr_q;
  assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        d_read;
  logic        d_write;
  logic [2:0]  d_func3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_misaligned;
  logic        m_using;
  logic        m_read;
  logic        m_write;
  logic [2:0]  m_func3;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:255];

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_pc(if_pc), .if_flush(if_flush),
    .if_valid(if_valid), .if_instr(if_instr),
    .d_read(d_read), .d_write(d_write), .d_func3(d_func3),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_misaligned(d_misaligned),
    .m_using(m_using), .m_read(m_read), .m_write(m_write),
    .m_func3(m_func3), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: combinational read, write at posedge.
  logic [7:0]  ma;
  logic [31:0] mword;
  always_comb begin
    ma      = m_addr[7:0];
    mword   = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    m_rdata = 32'h0;
    if (m_using) begin
      if (!m_read) begin
        m_rdata = {mem[{ma[7:2], 2'b11}], mem[{ma[7:2], 2'b10}],
                   mem[{ma[7:2], 2'b01}], mem[{ma[7:2], 2'b00}]};
      end else begin
        case (m_func3)
          3'd0: m_rdata = {{24{mword[7]}}, mword[7:0]};
          3'd1: m_rdata = {{16{mword[15]}}, mword[15:0]};
          3'd2: m_rdata = mword;
          3'd4: m_rdata = {24'h0, mword[7:0]};
          3'd5: m_rdata = {16'h0, mword[15:0]};
          default: m_rdata = 32'h0;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    if (m_using && m_write) begin
      mem[m_addr[7:0]] <= m_wdata[7:0];
      if (m_func3[1:0] != 2'd0) mem[m_addr[7:0] + 8'd1] <= m_wdata[15:8];
      if (m_func3[1:0] == 2'd2) begin
        mem[m_addr[7:0] + 8'd2] <= m_wdata[23:16];
        mem[m_addr[7:0] + 8'd3] <= m_wdata[31:24];
      end
    end
  end

  task automatic clear_data();
    d_read  = 1'b0;
    d_write = 1'b0;
    d_func3 = 3'd0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (if_valid !== 1'b0 || d_done !== 1'b0 || d_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: if_valid=%b d_done=%b d_mis=%b required 0 0 0", if_valid, d_done, d_misaligned);
    end
    n_tests++;
    if (if_instr !== 32'h0 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: if_instr=%h d_rdata=%h required 0 0", if_instr, d_rdata);
    end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    rst = 1'b0; if_req = 1'b1; if_pc = 32'd4;
    #1;
    n_tests++;
    if (m_using !== 1'b1 || m_read !== 1'b0 || m_addr !== 32'd4 || m_func3 !== 3'b010) begin
      n_fail++;
      $display("FAIL fetch_grant: using=%b read=%b addr=%h f3=%0d required 1 0 4 2", m_using, m_read, m_addr, m_func3);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if_valid !== 1'b1 || if_instr !== 32'h06402083) begin
      n_fail++;
      $display("FAIL fetch_rsp: valid=%b instr=%h required 1 06402083", if_valid, if_instr);
    end
    n_tests++;
    if (m_using !== 1'b0 || m_addr !== 32'h0 || m_func3 !== 3'd0) begin
      n_fail++;
      $display("FAIL fetch_no_regrant: using=%b addr=%h f3=%0d required 0 0 0", m_using, m_addr, m_func3);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if_valid !== 1'b0 || m_using !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_alternate: valid=%b using=%b required 0 1", if_valid, m_using);
    end
    if_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    @(negedge clk);
    if_req = 1'b1; if_pc = 32'd8;
    d_read = 1'b1; d_func3 = 3'd2; d_addr = 32'd100;
    #1;
    n_tests++;
    if (m_using !== 1'b1 || m_read !== 1'b1 || m_addr !== 32'd100) begin
      n_fail++;
      $display("FAIL contention_data_first: using=%b read=%b addr=%h required 1 1 64", m_using, m_read, m_addr);
    end
    @(posedge clk); #1;
    n_tests++;
    if (d_done !== 1'b1 || d_rdata !== 32'd17 || d_misaligned !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_d_rsp: done=%b rdata=%h mis=%b ivalid=%b required 1 11 0 0", d_done, d_rdata, d_misaligned, if_valid);
    end
    // d_read still held (stale) in the D_RSP cycle: fetch must win the port.
    n_tests++;
    if (m_using !== 1'b1 || m_read !== 1'b0 || m_addr !== 32'd8) begin
      n_fail++;
      $display("FAIL contention_fetch_in_drsp: using=%b read=%b addr=%h required 1 0 8", m_using, m_read, m_addr);
    end
    @(negedge clk);
    clear_data();
    @(posedge clk); #1;
    n_tests++;
    if (if_valid !== 1'b1 || if_instr !== 32'h00000013 || d_done !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_f_rsp: valid=%b instr=%h done=%b required 1 00000013 0", if_valid, if_instr, d_done);
    end
    if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int wcycles;
    wcycles = 0;
    @(negedge clk);
    d_write = 1'b1; d_func3 = 3'd2; d_addr = 32'd112; d_wdata = 32'd34;
    #1;
    if (m_write === 1'b1) wcycles++;
    n_tests++;
    if (m_wdata !== 32'd34 || m_addr !== 32'd112) begin
      n_fail++;
      $display("FAIL store_port: wdata=%h addr=%h required 22 70", m_wdata, m_addr);
    end
    @(posedge clk); #1;
    if (m_write === 1'b1) wcycles++;
    n_tests++;
    if (d_done !== 1'b1 || d_rdata !== 32'h00000011) begin
      n_fail++;
      $display("FAIL store_done: done=%b rdata=%h required 1 11 (unchanged)", d_done, d_rdata);
    end
    @(negedge clk);
    clear_data();
    #1;
    if (m_write === 1'b1) wcycles++;
    n_tests++;
    if (wcycles !== 1) begin
      n_fail++;
      $display("FAIL store_write_once: m_write cycles=%0d required 1", wcycles);
    end
    @(posedge clk);
    @(negedge clk);
    d_read = 1'b1; d_func3 = 3'd2; d_addr = 32'd112;
    @(posedge clk); #1;
    n_tests++;
    if (d_done !== 1'b1 || d_rdata !== 32'd34) begin
      n_fail++;
      $display("FAIL store_readback: done=%b rdata=%h required 1 22", d_done, d_rdata);
    end
    @(negedge clk);
    clear_data();
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s  [0:1];
    logic [31:0] adrs [0:1];
    f3s[0] = 3'd2; adrs[0] = 32'd102;
    f3s[1] = 3'd1; adrs[1] = 32'd101;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      d_read = 1'b1; d_func3 = f3s[i]; d_addr = adrs[i];
      #1;
      n_tests++;
      if (m_using !== 1'b0 || m_write !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned_port_%0d: using=%b write=%b required 0 0", i, m_using, m_write);
      end
      @(posedge clk); #1;
      n_tests++;
      if (d_done !== 1'b1 || d_misaligned !== 1'b1 || d_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL misaligned_rsp_%0d: done=%b mis=%b rdata=%h required 1 1 0", i, d_done, d_misaligned, d_rdata);
      end
      @(negedge clk);
      clear_data();
      @(posedge clk); #1;
    end
    // Byte loads are never misaligned.
    @(negedge clk);
    d_read = 1'b1; d_func3 = 3'd0; d_addr = 32'd101;
    #1;
    n_tests++;
    if (m_using !== 1'b1 || m_addr !== 32'd101) begin
      n_fail++;
      $display("FAIL byte_odd_grant: using=%b addr=%h required 1 65", m_using, m_addr);
    end
    @(posedge clk); #1;
    n_tests++;
    if (d_done !== 1'b1 || d_misaligned !== 1'b0 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL byte_odd_rsp: done=%b mis=%b rdata=%h required 1 0 0", d_done, d_misaligned, d_rdata);
    end
    @(negedge clk);
    clear_data();
    @(posedge clk);
    @(negedge clk);
    d_read = 1'b1; d_func3 = 3'd4; d_addr = 32'd100;
    @(posedge clk); #1;
    n_tests++;
    if (d_done !== 1'b1 || d_rdata !== 32'd17) begin
      n_fail++;
      $display("FAIL lbu_rsp: done=%b rdata=%h required 1 11", d_done, d_rdata);
    end
    @(negedge clk);
    clear_data();
    @(posedge clk);
    // Undefined load func3 passes through; memory returns 0.
    @(negedge clk);
    d_read = 1'b1; d_func3 = 3'd3; d_addr = 32'd100;
    @(posedge clk); #1;
    n_tests++;
    if (d_done !== 1'b1 || d_misaligned !== 1'b0 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL undef_func3: done=%b mis=%b rdata=%h required 1 0 0", d_done, d_misaligned, d_rdata);
    end
    @(negedge clk);
    clear_data();
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    @(negedge clk);
    if_req = 1'b1; if_pc = 32'd4; if_flush = 1'b1;
    #1;
    n_tests++;
    if (m_using !== 1'b1 || m_addr !== 32'd4) begin
      n_fail++;
      $display("FAIL flush_grant: using=%b addr=%h required 1 4", m_using, m_addr);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if_valid !== 1'b0 || if_instr !== 32'h00000013) begin
      n_fail++;
      $display("FAIL flush_drop: valid=%b instr=%h required 0 00000013", if_valid, if_instr);
    end
    if_flush = 1'b0; if_pc = 32'd7;
    #1;
    n_tests++;
    if (m_using !== 1'b1 || m_addr !== 32'd4) begin
      n_fail++;
      $display("FAIL flush_next_grant: using=%b addr=%h required 1 4", m_using, m_addr);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if_valid !== 1'b1 || if_instr !== 32'h06402083) begin
      n_fail++;
      $display("FAIL flush_refetch: valid=%b instr=%h required 1 06402083", if_valid, if_instr);
    end
    if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_store();
    @(negedge clk);
    d_write = 1'b1; d_func3 = 3'd2; d_addr = 32'd116; d_wdata = 32'hDEADBEEF;
    #1;
    n_tests++;
    if (m_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_store_pre: m_write=%b required 1", m_write);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (m_write !== 1'b0 || d_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_store_gate: m_write=%b d_done=%b required 0 0", m_write, d_done);
    end
    @(posedge clk); #1;
    clear_data();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (d_done !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_store_no_done: d_done=%b if_valid=%b required 0 0", d_done, if_valid);
    end
    n_tests++;
    if ({mem[119], mem[118], mem[117], mem[116]} !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_store_mem: bytes=%h required 0", {mem[119], mem[118], mem[117], mem[116]});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[7], mem[6], mem[5], mem[4]}       = 32'h06402083;
    {mem[11], mem[10], mem[9], mem[8]}     = 32'h00000013;
    {mem[103], mem[102], mem[101], mem[100]} = 32'd17;
    rst = 1'b1;
    if_req = 1'b0; if_pc = 32'h0; if_flush = 1'b0;
    clear_data();
    @(posedge clk); #1;
    @(posedge clk); #1;
    test_reset();
    test_fetch();
    test_contention();
    test_store_load();
    test_misaligned();
    test_flush();
    test_reset_store();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
